key_input: RTL
==============

Name: key_input

Overview:
- Memory-mapped read-side peripheral for push-buttons/switches; the CPU-facing counterpart of the write-only HEX display output port.
- Synchronises and debounces WIDTH active-low key inputs and latches press events in an edge-capture register.
- Exposes debounced state, edge capture and an IRQ mask through the same chip-select / read-write strobe bus.
- Drives a level interrupt to the SoC interrupt controller.

Parameters:
- WIDTH, 4, number of key inputs.
- DEBOUNCE_CYCLES, 500000, consecutive iClk cycles a synchronised input must differ from the stable value before the change is accepted (10 ms at 50 MHz); must be >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width.

Ports:
- iClk  input  1  system clock.
- iReset_n  input  1  asynchronous active-low reset.
- iChip_select_n  input  1  active-low chip select.
- iRead_n  input  1  active-low read strobe.
- iWrite_n  input  1  active-low write strobe.
- iAddress  input  2  register select.
- iWrite_data  input  32  write data.
- iKey  input  WIDTH  raw key pins, asynchronous, active-low (0 = pressed).
- oRead_data  output  32  registered read data.
- oIrq  output  1  level interrupt, active-high.

Behaviour:
- One clock domain (iClk); reset is asynchronous, active-low (iReset_n). All flops reset asynchronously.
- Reset values:
  - synchroniser flops, all ones (released);
  - stable state, all ones;
  - debounce counters, 0;
  - edge capture, 0;
  - mask, 0;
  - oRead_data, 0;
  - oIrq, 0.
- Synchroniser: 2-flop chain per bit; sync = second stage.
- Debounce, per bit, each cycle:
  - sync == stable: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: stable <= sync, cnt <= 0.
  - else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches stable. The counter restarts on any return to the stable value.
  - Pin-to-stable latency = 2 + DEBOUNCE_CYCLES cycles.
- Press detect: press[i] = stable_prev[i] & ~stable[i] (1->0 transition of stable). Pulse is 1 cycle. Releases are not captured.
- Register map (iAddress); bits above WIDTH read 0:
  - 0 DATA: read returns ~stable (1 = pressed). Writes ignored.
  - 1 EDGE: read returns edge capture. Write: bits set in iWrite_data[WIDTH-1:0] are cleared (write-1-to-clear).
  - 2 MASK: read/write, WIDTH bits.
  - 3: reserved; reads 0, writes ignored.
- Access qualifiers:
  - Read occurs when ~iChip_select_n & ~iRead_n.
  - Write occurs when ~iChip_select_n & ~iWrite_n.
  - Read and write asserted together: the write takes effect and the read returns the pre-write value.
- Read latency: 1 cycle. oRead_data is updated at the clock edge where the read is sampled and holds until the next read. No read means no change.
- Edge capture: edge[i] <= (edge[i] & ~clr[i]) | press[i]. If press and W1C clear hit the same bit in the same cycle, set wins (bit = 1).
- Reading EDGE does not clear it.
- oIrq is registered: oIrq <= |(edge & mask). Assertion lags the capture by 1 cycle. Deassertion occurs 1 cycle after clear or unmask.
- Reset mid-debounce: count is discarded and stable returns to released. A key still held after reset is re-accepted after 2 + DEBOUNCE_CYCLES cycles and produces a press event.

Decomposition:
- Shared package soc_pkg:
  - register address constants ADDR_DATA=0, ADDR_EDGE=1, ADDR_MASK=2;
  - DATA_W=32 bus width constant.
- Sub-module debounce_bit: holds synchroniser, counter and stable flop for one bit.
  - Parameters: DEBOUNCE_CYCLES, CNT_W.
  - Ports: iClk, iReset_n, iIn, oStable.
  - key_input instantiates WIDTH copies in a generate loop. Edge capture, mask and bus logic stay in the top module.

Test Plan (bench uses DEBOUNCE_CYCLES=4, WIDTH=4):
- Reset, then read addr 0 -> oRead_data = 0x0 one cycle after the strobe. Read addr 1 -> 0x0. oIrq = 0.
- Drive iKey=4'b1110 (key0 pressed) steadily -> stable bit0 falls exactly 6 cycles after the pin change. Read addr 0 -> 0x1. Read addr 1 -> 0x1.
- Pulse iKey[1] low for 3 cycles then high -> DATA never shows bit1, EDGE bit1 stays 0 (glitch rejected).
- Write MASK=0x1 with EDGE bit0 = 1 -> oIrq = 1 one cycle later. Write addr 1 data 0x1 -> EDGE = 0x0 and oIrq = 0 one cycle later.
- Arrange a key2 press pulse in the same cycle as a W1C write of 0x4 to addr 1 -> EDGE bit2 = 1 afterwards (set wins).
- Hold key3 pressed, assert iReset_n=0 mid-hold for 2 cycles -> all outputs 0 immediately. After release, DATA bit3 = 1 and EDGE bit3 = 1 after 6 more cycles.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared bus constants for the memory-mapped SoC peripherals.
package soc_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_EDGE = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;

endpackage

// File: rtl/debounce_bit.sv
// One key bit: two-flop synchroniser followed by a consecutive-cycle debounce counter.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic iClk,
  input  logic iReset_n,
  input  logic iIn,
  output logic oStable
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any return to the stable value restarts the count, so glitches never accumulate.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= iIn;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign oStable = stable_q;

endmodule

// File: rtl/key_input.sv
// Memory-mapped key/switch input port: debounced state, press edge capture, IRQ mask
// and a level interrupt towards the SoC interrupt controller.
module key_input
  import soc_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iChip_select_n,
  input  logic              iRead_n,
  input  logic              iWrite_n,
  input  logic [1:0]        iAddress,
  input  logic [DATA_W-1:0] iWrite_data,
  input  logic [WIDTH-1:0]  iKey,
  output logic [DATA_W-1:0] oRead_data,
  output logic              oIrq
);

  logic [WIDTH-1:0]  stable;
  logic [WIDTH-1:0]  stable_prev_q;
  logic [WIDTH-1:0]  press;
  logic [WIDTH-1:0]  clr;
  logic [WIDTH-1:0]  edge_cap_q;
  logic [WIDTH-1:0]  edge_cap_d;
  logic [WIDTH-1:0]  mask_q;
  logic [WIDTH-1:0]  mask_d;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;
  logic              irq_q;
  logic              irq_d;
  logic              rd_en;
  logic              wr_en;
  logic              unused_wdata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .iClk    (iClk),
      .iReset_n(iReset_n),
      .iIn     (iKey[g]),
      .oStable (stable[g])
    );
  end

  assign rd_en        = ~iChip_select_n & ~iRead_n;
  assign wr_en        = ~iChip_select_n & ~iWrite_n;
  assign unused_wdata = ^iWrite_data;

  // All terms use pre-edge register values, so a simultaneous read sees the pre-write state.
  always_comb begin
    rd_val = '0;
    case (iAddress)
      ADDR_DATA: rd_val[WIDTH-1:0] = ~stable;
      ADDR_EDGE: rd_val[WIDTH-1:0] = edge_cap_q;
      ADDR_MASK: rd_val[WIDTH-1:0] = mask_q;
      default:   rd_val            = '0;
    endcase

    rd_data_d = rd_en ? rd_val : rd_data_q;
    clr       = (wr_en && iAddress == ADDR_EDGE) ? iWrite_data[WIDTH-1:0] : '0;
    mask_d    = (wr_en && iAddress == ADDR_MASK) ? iWrite_data[WIDTH-1:0] : mask_q;

    // Keys are active-low: a press is a 1->0 step of the debounced level; set beats clear.
    press      = stable_prev_q & ~stable;
    edge_cap_d = (edge_cap_q & ~clr) | press;
    irq_d      = |(edge_cap_q & mask_q);
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      stable_prev_q <= '1;
      edge_cap_q    <= '0;
      mask_q        <= '0;
      rd_data_q     <= '0;
      irq_q         <= 1'b0;
    end else begin
      stable_prev_q <= stable;
      edge_cap_q    <= edge_cap_d;
      mask_q        <= mask_d;
      rd_data_q     <= rd_data_d;
      irq_q         <= irq_d;
    end
  end

  assign oRead_data = rd_data_q;
  assign oIrq       = irq_q;

endmodule
